speck_iterative_cipher: RTL and testbench
=========================================

# speck_iterative_cipher

Iterative, parametrised SPECK block-cipher core. It reuses one round datapath and one key-schedule step over `ROUNDS` cycles, with a start/busy/done handshake. It replaces the unrolled chain of per-round key-schedule and round instances that is sequenced by an external state machine. It sits between the host register interface and the cipher settings, and covers any SPECK word size and key length from one RTL source.

## Interface
Parameters:
- `WORD_W`, default 64: SPECK word size n; legal values are 16, 24, 32, 48, 64.
- `KEY_WORDS`, default 2: key words m; legal values are 2, 3, 4.
- `ROUNDS`, default 32: round count T, per the SPECK table for (n, m).

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request. Sampled only in IDLE.
- `mode`, in, 1: 0 = encrypt, 1 = decrypt. Sampled with `start`.
- `key`, in, `KEY_WORDS*WORD_W`: `[WORD_W-1:0]` = k0; the next words upward = l0, l1, …. Sampled with `start`.
- `block_in`, in, `2*WORD_W`: `[2W-1:W]` = x, `[W-1:0]` = y. Sampled with `start`.
- `busy`, out, 1: high from the cycle after `start` is accepted until `done`.
- `done`, out, 1: one-cycle pulse when `block_out` is valid.
- `block_out`, out, `2*WORD_W`: result, held until the next `done`.

## Operation
- Rotations: alpha = 7 and beta = 2 when `WORD_W`==16; otherwise alpha = 8 and beta = 3. All adds and subtracts are mod 2^`WORD_W`, and carries are discarded.
- Encrypt round:
  - x ← (ROR(x, alpha) + y) ^ k
  - y ← ROL(y, beta) ^ x_new
- Decrypt round:
  - y ← ROR(x ^ y, beta)
  - x ← ROL((x ^ k) − y_new, alpha)
- Key step i, where i is zero-extended to `WORD_W`:
  - l ← (k + ROR(l0, alpha)) ^ i
  - k ← ROL(k, beta) ^ l
  - The l-words form a `KEY_WORDS-1`-entry shift register.
- FSM, without the macro:
  - IDLE goes to ROUND on `start`.
  - ROUND runs `ROUNDS` cycles; round i uses k_i and computes k_{i+1} in parallel.
  - ROUND goes to DONE, then back to IDLE.
- FSM, with the macro: IDLE → EXPAND → ROUND → DONE → IDLE. See Configuration.
- `start` while not in IDLE is ignored. Inputs are not re-sampled, and no error is raised.
- Round counter width is `$clog2(ROUNDS)`. It wraps only by FSM exit and never overflows into a new operation.

## Timing
- Reset values: `busy`=0, `done`=0, `block_out`=0, FSM=IDLE, counter=0, all key and data registers 0.
- Reset mid-operation: the FSM returns to IDLE immediately. No `done` is produced, and `block_out` is cleared to 0.
- Encrypt latency, from the `start` edge to the `done` edge: `ROUNDS`+1 cycles. `block_out` is registered in the same edge that raises `done`.
- Decrypt latency (macro only): (`ROUNDS`−1) + `ROUNDS` + 1 cycles. Encrypt with the macro pays the same expansion cost.
- `busy` falls in the cycle `done` is high. A new `start` is accepted in the cycle after `done`, which is the IDLE cycle.
- Throughput: one block per `ROUNDS`+2 cycles without the macro.

## Configuration
- `SPECK_DECRYPT_EN` defined:
  - EXPAND state computes and stores all `ROUNDS` round keys in a `ROUNDS`×`WORD_W` register file, one per cycle. k0 is written on accept.
  - ROUND then reads index i for encrypt, or `ROUNDS`−1−i for decrypt, and applies the matching round function.
- `SPECK_DECRYPT_EN` undefined:
  - No key buffer and no EXPAND state; keys are generated on the fly.
  - `mode` is ignored and treated as 0, with no decrypt logic.

## Structure
- Package `speck_pkg`:
  - FSM state enum (IDLE, EXPAND, ROUND, DONE).
  - alpha/beta constant functions of `WORD_W`.
  - Parametric ROL/ROR functions.
- Sub-module `speck_round`: combinational single round (`mode`, x, y, k → x', y'). It is used for the data path only; the key step reuses the encrypt form with i in place of k.

## Test plan
- SPECK128/128, `mode`=0:
  - key = 0f0e0d0c0b0a0908_0706050403020100
  - `block_in` = 6c61766975716520_7469206564616d20
  - Required: `block_out` = a65d985179783265_7860fedf5c570d18, `done` exactly 33 cycles after `start`.
- SPECK32/64 (`WORD_W`=16, `KEY_WORDS`=4, `ROUNDS`=22):
  - key = 1918_1110_0908_0100
  - `block_in` = 6574_694c
  - Required: `block_out` = a868_42f2.
- With `SPECK_DECRYPT_EN`: decrypt the 128/128 ciphertext above with the same key. Required: the plaintext is recovered, and latency is 31+32+1 = 64 cycles.
- Second `start` pulse at cycle 10 of an operation. Required: it is ignored, and the first result and its timing are unchanged.
- `rst_n` low at round 15. Required: `busy`, `done` and `block_out` go to 0 asynchronously. A following `start` yields the correct ciphertext.
- Back-to-back operations, with `start` in the cycle after `done`. Required: both accepted, results correct, and `done` pulses 34 cycles apart.

Source files
------------

// File: rtl/speck_pkg.sv
// speck_pkg: shared FSM encoding, SPECK rotation constants and width-generic rotate helpers.
// Latency: n/a (types and constant/combinational functions only).
// Backpressure: n/a.
package speck_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_ROUND, ST_DONE} state_t;

   // Rotates are done on a 64-bit carrier; callers zero-extend and truncate.
   localparam int unsigned MAX_W = 64;
   typedef logic [MAX_W-1:0] word_t;

   function automatic int unsigned speck_alpha(input int unsigned n);
      return (n == 16) ? 32'd7 : 32'd8;
   endfunction

   function automatic int unsigned speck_beta(input int unsigned n);
      return (n == 16) ? 32'd2 : 32'd3;
   endfunction

   function automatic word_t width_mask(input int unsigned n);
      if (n >= MAX_W) return '1;
      return (word_t'(1) << n) - word_t'(1);
   endfunction

   // Rotate right by s within the low n bits; bits above n are ignored and cleared.
   function automatic word_t ror(input word_t v, input int unsigned n, input int unsigned s);
      word_t m;
      word_t vm;
      m  = width_mask(n);
      vm = v & m;
      return ((vm >> s) | (vm << (n - s))) & m;
   endfunction

   function automatic word_t rol(input word_t v, input int unsigned n, input int unsigned s);
      return ror(v, n, n - s);
   endfunction

endpackage

// File: rtl/speck_round.sv
// speck_round: one combinational SPECK round, encrypt (mode_i=0) or its inverse (mode_i=1).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module speck_round
   import speck_pkg::*;
#(
   parameter int unsigned WORD_W = 64
) (
   input  logic              mode_i,
   input  logic [WORD_W-1:0] x_i,
   input  logic [WORD_W-1:0] y_i,
   input  logic [WORD_W-1:0] k_i,
   output logic [WORD_W-1:0] x_o,
   output logic [WORD_W-1:0] y_o
);

   localparam int unsigned ALPHA = speck_alpha(WORD_W);
   localparam int unsigned BETA  = speck_beta(WORD_W);

   logic [WORD_W-1:0] enc_x, enc_y, dec_x, dec_y, dec_diff;

   // Both round directions; the decrypt half folds away when mode_i is tied low.
   always_comb begin
      enc_x    = (WORD_W'(ror(word_t'(x_i), WORD_W, ALPHA)) + y_i) ^ k_i;
      enc_y    = WORD_W'(rol(word_t'(y_i), WORD_W, BETA)) ^ enc_x;
      dec_y    = WORD_W'(ror(word_t'(x_i ^ y_i), WORD_W, BETA));
      dec_diff = (x_i ^ k_i) - dec_y;
      dec_x    = WORD_W'(rol(word_t'(dec_diff), WORD_W, ALPHA));
      x_o      = mode_i ? dec_x : enc_x;
      y_o      = mode_i ? dec_y : enc_y;
   end

endmodule

// File: rtl/speck_iterative_cipher.sv
// speck_iterative_cipher: iterative SPECK, one round + one key step per cycle; SPECK_DECRYPT_EN adds round-key file + decrypt.
// Latency: ROUNDS+1 cycles start->done; with SPECK_DECRYPT_EN (ROUNDS-1)+ROUNDS+1 for either direction.
// Backpressure: none; start is taken only in IDLE and ignored otherwise, block_out held until next done.
module speck_iterative_cipher
   import speck_pkg::*;
#(
   parameter int unsigned WORD_W    = 64,
   parameter int unsigned KEY_WORDS = 2,
   parameter int unsigned ROUNDS    = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          mode,
   input  logic [KEY_WORDS*WORD_W-1:0]   key,
   input  logic [2*WORD_W-1:0]           block_in,
   output logic                          busy,
   output logic                          done,
   output logic [2*WORD_W-1:0]           block_out
);

   localparam int unsigned CW = $clog2(ROUNDS);
   localparam int unsigned LW = KEY_WORDS - 1;

   state_t                     state_q;
   logic [CW-1:0]              cnt_q;
   logic [WORD_W-1:0]          x_q, y_q, k_q;
   logic [LW-1:0][WORD_W-1:0]  l_q, l_d;
   logic [WORD_W-1:0]          x_d, y_d, ks_l, ks_k, rnd_key;
   logic                       rnd_mode;
   logic                       busy_q, done_q;
   logic [2*WORD_W-1:0]        block_out_q;

`ifdef SPECK_DECRYPT_EN
   logic                       mode_q;
   logic [WORD_W-1:0]          rk_q [ROUNDS];
   logic [CW-1:0]              rk_idx;

   // Decrypt walks the stored round keys backwards.
   always_comb begin
      rk_idx = mode_q ? (CW'(ROUNDS - 1) - cnt_q) : cnt_q;
   end
   assign rnd_key  = rk_q[rk_idx];
   assign rnd_mode = mode_q;
`else
   logic unused_mode;
   assign unused_mode = mode;
   assign rnd_key     = k_q;
   assign rnd_mode    = 1'b0;
`endif

   // Key step is the encrypt round with (l0, k, i) in place of (x, y, k).
   speck_round #(.WORD_W(WORD_W)) u_key_step (
      .mode_i (1'b0),
      .x_i    (l_q[0]),
      .y_i    (k_q),
      .k_i    (WORD_W'(cnt_q)),
      .x_o    (ks_l),
      .y_o    (ks_k)
   );

   speck_round #(.WORD_W(WORD_W)) u_data_round (
      .mode_i (rnd_mode),
      .x_i    (x_q),
      .y_i    (y_q),
      .k_i    (rnd_key),
      .x_o    (x_d),
      .y_o    (y_d)
   );

   // l-word shift register: drop l0, append the freshly generated word at the top.
   always_comb begin
      l_d = l_q;
      for (int j = 0; j < int'(LW) - 1; j++) l_d[j] = l_q[j+1];
      l_d[LW-1] = ks_l;
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         k_q         <= '0;
         l_q         <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         block_out_q <= '0;
`ifdef SPECK_DECRYPT_EN
         mode_q      <= 1'b0;
         for (int i = 0; i < int'(ROUNDS); i++) rk_q[i] <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  x_q    <= block_in[2*WORD_W-1:WORD_W];
                  y_q    <= block_in[WORD_W-1:0];
                  k_q    <= key[WORD_W-1:0];
                  l_q    <= key[KEY_WORDS*WORD_W-1:WORD_W];
                  cnt_q  <= '0;
                  busy_q <= 1'b1;
`ifdef SPECK_DECRYPT_EN
                  mode_q   <= mode;
                  rk_q[0]  <= key[WORD_W-1:0];
                  state_q  <= ST_EXPAND;
`else
                  state_q  <= ST_ROUND;
`endif
               end
            end
`ifdef SPECK_DECRYPT_EN
            ST_EXPAND: begin
               k_q                    <= ks_k;
               l_q                    <= l_d;
               rk_q[cnt_q + CW'(1)]   <= ks_k;
               if (cnt_q == CW'(ROUNDS - 2)) begin
                  cnt_q   <= '0;
                  state_q <= ST_ROUND;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
`endif
            ST_ROUND: begin
               x_q <= x_d;
               y_q <= y_d;
`ifndef SPECK_DECRYPT_EN
               k_q <= ks_k;
               l_q <= l_d;
`endif
               if (cnt_q == CW'(ROUNDS - 1)) begin
                  cnt_q   <= '0;
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_DONE: begin
               block_out_q <= {x_q, y_q};
               done_q      <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign block_out = block_out_q;

endmodule

// File: tb/tb_speck_iterative_cipher.sv
// tb_speck_iterative_cipher: scoreboard bench for SPECK128/128 and SPECK32/64 instances (honours SPECK_DECRYPT_EN).
// Latency: expected done cycle is pushed with each accepted start and compared by the monitor.
// Backpressure: n/a; start pulses are issued only when the bench expects IDLE (except the ignored-start case).
module tb_speck_iterative_cipher;

`ifdef SPECK_DECRYPT_EN
   localparam bit DEC = 1'b1;
`else
   localparam bit DEC = 1'b0;
`endif
   localparam int LAT_A = DEC ? 64 : 33;
   localparam int LAT_B = DEC ? 44 : 23;

   localparam logic [127:0] KA = 128'h0f0e0d0c0b0a0908_0706050403020100;
   localparam logic [127:0] PA = 128'h6c61766975716520_7469206564616d20;
   localparam logic [127:0] CA = 128'ha65d985179783265_7860fedf5c570d18;
   localparam logic [63:0]  KB = 64'h1918_1110_0908_0100;
   localparam logic [31:0]  PB = 32'h6574_694c;
   localparam logic [31:0]  CB = 32'ha868_42f2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int compared   = 0;
   int mismatched = 0;

   logic         a_start, a_mode, a_busy, a_done;
   logic [127:0] a_key, a_blk, a_out;
   logic         b_start, b_mode, b_busy, b_done;
   logic [63:0]  b_key;
   logic [31:0]  b_blk, b_out;

   speck_iterative_cipher #(.WORD_W(64), .KEY_WORDS(2), .ROUNDS(32)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .mode(a_mode), .key(a_key),
      .block_in(a_blk), .busy(a_busy), .done(a_done), .block_out(a_out)
   );

   speck_iterative_cipher #(.WORD_W(16), .KEY_WORDS(4), .ROUNDS(22)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .mode(b_mode), .key(b_key),
      .block_in(b_blk), .busy(b_busy), .done(b_done), .block_out(b_out)
   );

   typedef struct {
      logic [127:0] blk;
      int unsigned  t;
   } exp_t;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
      compared++;
      if (act !== exp_v) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Reference model: full key schedule first, then all rounds, on 64-bit carriers.
   function automatic logic [63:0] msk(input int n);
      return (n == 64) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << n) - 64'd1);
   endfunction

   function automatic logic [63:0] tror(input logic [63:0] v, input int n, input int s);
      logic [63:0] vm;
      vm = v & msk(n);
      return ((vm >> s) | (vm << (n - s))) & msk(n);
   endfunction

   function automatic logic [63:0] trol(input logic [63:0] v, input int n, input int s);
      return tror(v, n, n - s);
   endfunction

   function automatic logic [127:0] model(input logic [255:0] key, input logic [127:0] blk,
                                          input int n, input int m, input int t, input bit dec);
      logic [63:0] k [64];
      logic [63:0] l [72];
      logic [63:0] x, y, mk;
      int a, b;
      a  = (n == 16) ? 7 : 8;
      b  = (n == 16) ? 2 : 3;
      mk = msk(n);
      k[0] = key[63:0] & mk;
      for (int j = 0; j < m - 1; j++) l[j] = 64'(key >> (n * (j + 1))) & mk;
      for (int i = 0; i < t - 1; i++) begin
         l[i+m-1] = ((k[i] + tror(l[i], n, a)) & mk) ^ 64'(i);
         k[i+1]   = trol(k[i], n, b) ^ l[i+m-1];
      end
      x = 64'(blk >> n) & mk;
      y = blk[63:0] & mk;
      if (!dec) begin
         for (int i = 0; i < t; i++) begin
            x = ((tror(x, n, a) + y) & mk) ^ k[i];
            y = trol(y, n, b) ^ x;
         end
      end else begin
         for (int i = t - 1; i >= 0; i--) begin
            y = tror(x ^ y, n, b);
            x = trol(((x ^ k[i]) - y) & mk, n, a);
         end
      end
      return (128'(x) << n) | 128'(y);
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (a_done === 1'b1) begin
         if (qa.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL a_unexpected_done: got done=1, expected none (cycle %0d)", cyc);
         end else begin
            ea = qa.pop_front();
            check("a_block_out", a_out, ea.blk);
            check("a_done_cycle", 128'(cyc), 128'(ea.t));
            check("a_busy_at_done", 128'(a_busy), 128'(0));
         end
      end
      if (b_done === 1'b1) begin
         if (qb.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL b_unexpected_done: got done=1, expected none (cycle %0d)", cyc);
         end else begin
            eb = qb.pop_front();
            check("b_block_out", 128'(b_out), eb.blk);
            check("b_done_cycle", 128'(cyc), 128'(eb.t));
            check("b_busy_at_done", 128'(b_busy), 128'(0));
         end
      end
   end

   // Called at a negedge: present a start for one cycle and record what must come back.
   task automatic go_a(input logic [127:0] k, input logic [127:0] blk, input bit m, input logic [127:0] exp_v);
      a_key = k; a_blk = blk; a_mode = m; a_start = 1'b1;
      qa.push_back('{exp_v, cyc + 1 + LAT_A});
      @(negedge clk);
      a_start = 1'b0;
      #1 check("a_busy_after_accept", 128'(a_busy), 128'(1));
   endtask

   task automatic go_b(input logic [63:0] k, input logic [31:0] blk, input bit m, input logic [31:0] exp_v);
      b_key = k; b_blk = blk; b_mode = m; b_start = 1'b1;
      qb.push_back('{128'(exp_v), cyc + 1 + LAT_B});
      @(negedge clk);
      b_start = 1'b0;
      #1 check("b_busy_after_accept", 128'(b_busy), 128'(1));
   endtask

   task automatic wait_done_a();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (a_done === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         compared++; mismatched++;
         $display("FAIL a_wait_done: got no done, expected done within 200 cycles");
      end
   endtask

   task automatic drain();
      bit empty;
      empty = 1'b0;
      for (int i = 0; i < 300 && !empty; i++) begin
         @(negedge clk);
         #1;
         if (qa.size() == 0 && qb.size() == 0) empty = 1'b1;
      end
      if (!empty) begin
         compared++; mismatched++;
         $display("FAIL drain_timeout: got %0d/%0d pending, expected 0/0", qa.size(), qb.size());
         qa.delete();
         qb.delete();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion, expected finish within 1 ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [127:0] rk, rp, r;
      logic [63:0]  bk;
      logic [31:0]  bp;
      bit           m;

      rst_n = 1'b0;
      a_start = 1'b0; a_mode = 1'b0; a_key = '0; a_blk = '0;
      b_start = 1'b0; b_mode = 1'b0; b_key = '0; b_blk = '0;
      repeat (3) @(negedge clk);
      check("a_reset_busy", 128'(a_busy), 128'(0));
      check("a_reset_done", 128'(a_done), 128'(0));
      check("a_reset_block_out", a_out, 128'(0));
      check("b_reset_busy", 128'(b_busy), 128'(0));
      check("b_reset_done", 128'(b_done), 128'(0));
      check("b_reset_block_out", 128'(b_out), 128'(0));
      @(negedge clk) rst_n = 1'b1;

      // Published vectors.
      @(negedge clk) go_a(KA, PA, 1'b0, CA);
      go_b(KB, PB, 1'b0, CB);
      drain();
      if (DEC) begin
         @(negedge clk) go_a(KA, CA, 1'b1, PA);
         go_b(KB, CB, 1'b1, PB);
         drain();
      end

      // A second start mid-operation with different data must be ignored.
      @(negedge clk) go_a(KA, PA, 1'b0, CA);
      repeat (9) @(negedge clk);
      a_key = {$urandom, $urandom, $urandom, $urandom};
      a_blk = {$urandom, $urandom, $urandom, $urandom};
      a_start = 1'b1;
      @(negedge clk) a_start = 1'b0;
      drain();

      // Asynchronous reset mid-run clears outputs; the next operation is clean.
      @(negedge clk) go_a(KA, PA, 1'b0, CA);
      repeat (15) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("a_midreset_busy", 128'(a_busy), 128'(0));
      check("a_midreset_done", 128'(a_done), 128'(0));
      check("a_midreset_block_out", a_out, 128'(0));
      qa.delete();
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk) go_a(KA, PA, 1'b0, CA);
      drain();

      // Back-to-back: each start is presented in the cycle done is high.
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rk = {$urandom, $urandom, $urandom, $urandom};
         rp = {$urandom, $urandom, $urandom, $urandom};
         go_a(rk, rp, 1'b0, model({128'b0, rk}, rp, 64, 2, 32, 1'b0));
         wait_done_a();
      end
      drain();

      // Random operations on both widths; mode only matters with decrypt built in.
      for (int i = 0; i < 12; i++) begin
         rk = {$urandom, $urandom, $urandom, $urandom};
         rp = {$urandom, $urandom, $urandom, $urandom};
         m  = 1'($urandom_range(0, 1));
         @(negedge clk) go_a(rk, rp, m, model({128'b0, rk}, rp, 64, 2, 32, DEC && m));
         bk = {$urandom, $urandom};
         bp = $urandom;
         r  = model({192'b0, bk}, {96'b0, bp}, 16, 4, 22, DEC && m);
         go_b(bk, bp, m, r[31:0]);
         drain();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
